sw_dir_packer: RTL and testbench

// - Downstream of each SmithWatermanPE: collects the 4-bit traceback nibbles (dir/dir_valid/dir_addr)
//   the PE emits once per computed cell, packs PACK consecutive-column nibbles into one word, and

---
 rtl/sw_pkg.sv | 22 ++
 rtl/sw_dir_packer_if.sv | 34 +++
 rtl/sw_dir_fifo.sv | 54 +++++
 rtl/sw_dir_packer.sv | 131 +++++++++++++
 tb/tb_sw_dir_packer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared types for the Smith-Waterman traceback packer.
// Nibble encodings and packed-word layout.
package sw_pkg;

  localparam int DIR_W    = 4;
  localparam int LOG_PACK = 3;
  localparam int PACK     = 1 << LOG_PACK;
  localparam int WORD_W   = PACK * DIR_W;

  typedef enum logic [1:0] {
    DIR_ZERO  = 2'd0,
    DIR_VER   = 2'd1,
    DIR_HOR   = 2'd2,
    DIR_MATCH = 2'd3
  } dir_src_e;

  localparam int DIR_F_OPEN_BIT = 2;
  localparam int DIR_E_OPEN_BIT = 3;

  typedef logic [WORD_W-1:0] dir_word_t;

endpackage

// File: rtl/sw_dir_packer_if.sv
// RAM write port of the traceback packer.
// Optional wr_parity lanes under DIR_PACK_PARITY_EN.
interface sw_dir_packer_if #(
  parameter int AW = 7,
  parameter int DW = 32,
  parameter int PK = 8
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [PK-1:0] wr_mask;
`ifdef DIR_PACK_PARITY_EN
  logic [PK-1:0] wr_parity;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, wr_parity,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, wr_parity,
    output wr_ready
  );
`else
  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask,
    output wr_ready
  );
`endif
endinterface

// File: rtl/sw_dir_fifo.sv
// Small synchronous word FIFO, async active-low reset.
// Push on full is accepted only if a pop happens the same cycle.
module sw_dir_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  // Pointer update; clear restarts the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (clr_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wp_q[AW-1:0]] <= din_i;
    end
  end
endmodule

// File: rtl/sw_dir_packer.sv
// Packs PE traceback nibbles into RAM words with a stall FIFO.
// Define DIR_PACK_PARITY_EN to add per-lane wr_parity.
module sw_dir_packer
  import sw_pkg::*;
#(
  parameter int REF_LEN_WIDTH = 10,
  parameter int DIR_W_P       = DIR_W,
  parameter int LOG_PACK_P    = LOG_PACK,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     dir_valid,
  input  logic [REF_LEN_WIDTH-1:0] dir_addr,
  input  logic [DIR_W_P-1:0]       dir,
  input  logic                     flush,
  output logic                     busy,
  output logic                     overflow,
  sw_dir_packer_if.master          wr
);
  localparam int PK = 1 << LOG_PACK_P;
  localparam int DW = PK * DIR_W_P;
  localparam int AW = REF_LEN_WIDTH - LOG_PACK_P;
`ifdef DIR_PACK_PARITY_EN
  localparam int EW = AW + DW + PK + PK;
`else
  localparam int EW = AW + DW + PK;
`endif

  logic [AW-1:0]         acc_word_q, acc_word_d;
  logic [DW-1:0]         acc_data_q, acc_data_d;
  logic [PK-1:0]         acc_mask_q, acc_mask_d;
  logic                  pend_q, pend_d;
  logic                  ovf_q;
  logic [LOG_PACK_P-1:0] lane;
  logic [AW-1:0]         word_in;
  logic                  acc_nz, push;
  logic [EW-1:0]         fifo_din, fifo_dout;
  logic                  f_full, f_empty, f_drop, pop;

  assign lane    = dir_addr[LOG_PACK_P-1:0];
  assign word_in = dir_addr[REF_LEN_WIDTH-1:LOG_PACK_P];
  assign acc_nz  = |acc_mask_q;

  // Push decision and next accumulator state.
  always_comb begin
    acc_word_d = acc_word_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    pend_d     = pend_q;
    push = !start && ((&acc_mask_q) ||
           (dir_valid && acc_nz && word_in != acc_word_q) ||
           ((flush || pend_q) && acc_nz && !dir_valid));
    if (start) begin
      acc_word_d = '0;
      acc_data_d = '0;
      acc_mask_d = '0;
      pend_d     = 1'b0;
    end else begin
      if (push) begin
        acc_data_d = '0;
        acc_mask_d = '0;
      end
      if (dir_valid) begin
        if (push || !acc_nz) begin
          acc_word_d = word_in;
          acc_data_d = '0;
          acc_mask_d = '0;
        end
        acc_data_d[int'(lane)*DIR_W_P +: DIR_W_P] = dir;
        acc_mask_d[lane] = 1'b1;
      end
      if (flush && dir_valid) pend_d = 1'b1;
      else if (push || !acc_nz) pend_d = 1'b0;
    end
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_word_q <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      acc_word_q <= acc_word_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      pend_q     <= pend_d;
      ovf_q      <= start ? 1'b0 : (ovf_q | f_drop);
    end
  end

`ifdef DIR_PACK_PARITY_EN
  logic [PK-1:0] acc_par;
  for (genvar k = 0; k < PK; k++) begin : g_par
    assign acc_par[k] = ^acc_data_q[k*DIR_W_P +: DIR_W_P];
  end
  assign fifo_din = {acc_par, acc_mask_q, acc_data_q, acc_word_q};
  assign wr.wr_parity = f_empty ? '0 : fifo_dout[AW+DW+PK +: PK];
`else
  assign fifo_din = {acc_mask_q, acc_data_q, acc_word_q};
`endif

  assign pop = wr.wr_valid && wr.wr_ready;

  sw_dir_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .drop_o  (f_drop)
  );

  assign wr.wr_valid = !f_empty;
  assign wr.wr_addr  = f_empty ? '0 : fifo_dout[0 +: AW];
  assign wr.wr_data  = f_empty ? '0 : fifo_dout[AW +: DW];
  assign wr.wr_mask  = f_empty ? '0 : fifo_dout[AW+DW +: PK];
  assign busy        = acc_nz || !f_empty || pend_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_sw_dir_packer.sv
// Scoreboard bench for sw_dir_packer.
// Expected words queued at drive time, checked on accept.
module tb_sw_dir_packer;
  import sw_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir_valid = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] dir_addr = '0;
  logic [3:0] dir = '0;
  logic       busy, overflow;

  sw_dir_packer_if #(.AW(7), .DW(32), .PK(8)) wr_if ();

  sw_dir_packer #(
    .REF_LEN_WIDTH (10),
    .DIR_W_P       (4),
    .LOG_PACK_P    (3),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir_valid (dir_valid),
    .dir_addr  (dir_addr),
    .dir       (dir),
    .flush     (flush),
    .busy      (busy),
    .overflow  (overflow),
    .wr        (wr_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
    logic [7:0]  m;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(int a, int v, bit fl = 1'b0);
    logic [31:0] av, vv;
    av = a;
    vv = v;
    dir_addr  = av[9:0];
    dir       = vv[3:0];
    dir_valid = 1'b1;
    flush     = fl;
    @(posedge clk); #1;
    dir_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(string tag);
    int n = 0;
    while ((q.size() != 0 || wr_if.wr_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  // Compare each accepted word against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && wr_if.wr_valid && wr_if.wr_ready) begin
      if (q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", wr_if.wr_addr, e.a);
        check("wr_data", wr_if.wr_data, e.d);
        check("wr_mask", wr_if.wr_mask, e.m);
`ifdef DIR_PACK_PARITY_EN
        begin
          logic [7:0] p;
          for (int k = 0; k < 8; k++) p[k] = ^e.d[k*4 +: 4];
          check("wr_parity", wr_if.wr_parity, p);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [31:0] d;
    wr_if.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", wr_if.wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", wr_if.wr_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full word 0..7, values 1..8.
    e = '{a: 7'd0, d: 32'h8765_4321, m: 8'hFF};
    q.push_back(e);
    for (int i = 0; i < 8; i++) send(i, i + 1);
    check("lat_t1_valid", wr_if.wr_valid, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", wr_if.wr_valid, 1);
    drain("drain_full");

    // Partial word with flush.
    e = '{a: 7'd0, d: 32'h0000_0753, m: 8'h07};
    q.push_back(e);
    send(0, 3); send(1, 5); send(2, 7);
    check("busy_partial", busy, 1);
    do_flush();
    drain("drain_flush");
    check("busy_after_flush", busy, 0);

    // Word change pushes old word.
    e = '{a: 7'd0, d: 32'h0BA0_0000, m: 8'h60};
    q.push_back(e);
    send(5, 10); send(6, 11);
    e = '{a: 7'd1, d: 32'h0000_00C0, m: 8'h02};
    send(9, 12);
    q.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    check("word_change_q", q.size(), 1);
    check("busy_word1", busy, 1);
    do_flush();
    drain("drain_word1");

    // Stall with overflow.
    wr_if.wr_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      d = '0;
      for (int k = 0; k < 8; k++) begin
        int v;
        v = (w == 0 && k == 0) ? 15 : int'($urandom_range(15));
        d[k*4 +: 4] = v[3:0];
        send(w * 8 + k, v);
      end
      if (w < 4) begin
        e = '{a: w[6:0], d: d, m: 8'hFF};
        q.push_back(e);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("ovf_set", overflow, 1);
    check("stall_stable_addr", wr_if.wr_addr, 0);
    wr_if.wr_ready = 1'b1;
    drain("drain_stall");
    check("ovf_sticky", overflow, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Flush together with the last nibble.
    e = '{a: 7'd0, d: 32'h0000_9021, m: 8'h0B};
    q.push_back(e);
    send(0, 1); send(1, 2);
    send(3, 9, 1'b1);
    check("fl_dv_t1", wr_if.wr_valid, 0);
    @(posedge clk); #1;
    check("fl_dv_t2", wr_if.wr_valid, 1);
    drain("drain_fl_dv");

    // Async reset with a write pending.
    wr_if.wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16 + i, 15 - i);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", wr_if.wr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_valid", wr_if.wr_valid, 0);
    check("arst_data", wr_if.wr_data, 0);
    check("arst_mask", wr_if.wr_mask, 0);
    check("arst_addr", wr_if.wr_addr, 0);
    check("arst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_if.wr_ready = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
